// File: rtl/aes_vec_seq.sv
// Vector sequencer: replays stored plaintext/key/expected triples into a pipelined
// AES core at one per cycle and scores each ciphertext as it comes back.
module aes_vec_seq #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 8,
  parameter int LAT    = 21,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_state,
  input  logic [DATA_W-1:0] wr_key,
  input  logic [DATA_W-1:0] wr_exp,
  input  logic [ADDR_W:0]   num_vec,
  input  logic              loop_en,
  input  logic              start,
  input  logic              stop,
  output logic [DATA_W-1:0] core_state,
  output logic [DATA_W-1:0] core_key,
  input  logic [DATA_W-1:0] core_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [15:0]       vec_cnt,
  output logic [ADDR_W-1:0] first_err_idx
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_N = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_N   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  state_t state_reg, state_next;

  logic [DATA_W-1:0] mem_state [DEPTH];
  logic [DATA_W-1:0] mem_key   [DEPTH];
  logic [DATA_W-1:0] mem_exp   [DEPTH];

  logic [ADDR_W-1:0] rd_idx_reg, rd_idx_next;
  logic [ADDR_W:0]   n_reg, n_next;
  logic              stop_seen_reg, stop_seen_next;
  logic [LAT-1:0]    vld_reg;
  logic [ADDR_W-1:0] idx_line_reg [LAT];
  logic [15:0]       err_cnt_reg, vec_cnt_reg;
  logic [ADDR_W-1:0] first_err_reg;

  logic              issue, last_slot, drain_empty, cmp_en, mismatch, run_start;
  logic [ADDR_W:0]   num_eff;

  assign issue     = (state_reg == ISSUE);
  assign busy      = (state_reg == ISSUE) || (state_reg == DRAIN);
  assign done      = (state_reg == DONE);
  assign pass      = done && (err_cnt_reg == 16'd0);
  assign num_eff   = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
  assign last_slot = (({1'b0, rd_idx_reg} + ONE_N) == n_reg);
  assign cmp_en    = vld_reg[LAT-1];
  assign mismatch  = (core_out != mem_exp[idx_line_reg[LAT-1]]);

  assign core_state    = issue ? mem_state[rd_idx_reg] : '0;
  assign core_key      = issue ? mem_key[rd_idx_reg]   : '0;
  assign err_cnt       = err_cnt_reg;
  assign vec_cnt       = vec_cnt_reg;
  assign first_err_idx = first_err_reg;

  // Memory is frozen while a run is in flight so in-flight compares stay coherent.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      mem_state[wr_addr] <= wr_state;
      mem_key[wr_addr]   <= wr_key;
      mem_exp[wr_addr]   <= wr_exp;
    end
  end

  // Line empties on the next edge once only the final stage may still be set.
  always_comb begin
    drain_empty = 1'b1;
    for (int i = 0; i < LAT-1; i++) begin
      if (vld_reg[i]) drain_empty = 1'b0;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rd_idx_next    = rd_idx_reg;
    n_next         = n_reg;
    stop_seen_next = stop_seen_reg;
    run_start      = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          run_start      = 1'b1;
          n_next         = num_eff;
          rd_idx_next    = '0;
          stop_seen_next = 1'b0;
          state_next     = (num_eff == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (stop) stop_seen_next = 1'b1;
        if (last_slot) begin
          rd_idx_next = '0;
          if (!(loop_en && !stop_seen_reg && !stop)) state_next = DRAIN;
        end else begin
          rd_idx_next = rd_idx_reg + ONE_A;
        end
      end
      DRAIN: begin
        if (drain_empty) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      rd_idx_reg    <= '0;
      n_reg         <= '0;
      stop_seen_reg <= 1'b0;
      vld_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      rd_idx_reg    <= rd_idx_next;
      n_reg         <= n_next;
      stop_seen_reg <= stop_seen_next;
      vld_reg[0]    <= issue;
      for (int i = 1; i < LAT; i++) vld_reg[i] <= vld_reg[i-1];
    end
  end

  always_ff @(posedge clk) begin
    idx_line_reg[0] <= rd_idx_reg;
    for (int i = 1; i < LAT; i++) idx_line_reg[i] <= idx_line_reg[i-1];
  end

  // err_cnt==0 doubles as "no mismatch yet", since the counter saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_reg   <= '0;
      vec_cnt_reg   <= '0;
      first_err_reg <= '0;
    end else if (run_start) begin
      err_cnt_reg   <= '0;
      vec_cnt_reg   <= '0;
      first_err_reg <= '0;
    end else if (cmp_en) begin
      if (vec_cnt_reg != 16'hFFFF) vec_cnt_reg <= vec_cnt_reg + 16'd1;
      if (mismatch) begin
        if (err_cnt_reg == 16'd0) first_err_reg <= idx_line_reg[LAT-1];
        if (err_cnt_reg != 16'hFFFF) err_cnt_reg <= err_cnt_reg + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_vec_seq.sv
// Bench for aes_vec_seq: an XOR stand-in core with LAT-cycle delay, and a run-level
// reference model that predicts issue order, counts and timing from the stored vectors.
module tb_aes_vec_seq;
  localparam int DW  = 128;
  localparam int DEP = 8;
  localparam int LAT = 21;
  localparam int AW  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_state = '0, wr_key = '0, wr_exp = '0;
  logic [AW:0]   num_vec = '0;
  logic          loop_en = 1'b0, start = 1'b0, stop = 1'b0;
  logic [DW-1:0] core_state, core_key, core_out;
  logic          busy, done, pass;
  logic [15:0]   err_cnt, vec_cnt;
  logic [AW-1:0] first_err_idx;

  logic [DW-1:0] mst [DEP];
  logic [DW-1:0] mky [DEP];
  logic [DW-1:0] mex [DEP];
  logic [DW-1:0] pipe [LAT];

  int errors = 0;
  int checks = 0;

  aes_vec_seq #(.DATA_W(DW), .DEPTH(DEP), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_state(wr_state),
    .wr_key(wr_key), .wr_exp(wr_exp), .num_vec(num_vec), .loop_en(loop_en),
    .start(start), .stop(stop), .core_state(core_state), .core_key(core_key),
    .core_out(core_out), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .vec_cnt(vec_cnt), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  // Stand-in core: ciphertext = state ^ key, LAT registered stages.
  always @(posedge clk) begin
    pipe[0] <= core_state ^ core_key;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign core_out = pipe[LAT-1];

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic write_slot(input int idx, input logic [DW-1:0] st, input logic [DW-1:0] ky,
                            input logic [DW-1:0] ex);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(idx); wr_state = st; wr_key = ky; wr_exp = ex;
    @(negedge clk);
    wr_en = 1'b0;
    mst[idx] = st; mky[idx] = ky; mex[idx] = ex;
  endtask

  task automatic fill_slots(input logic [DEP-1:0] bad_mask);
    for (int i = 0; i < DEP; i++) begin
      logic [DW-1:0] st, ky, ex;
      st = rnd128(); ky = rnd128(); ex = st ^ ky;
      if (bad_mask[i]) ex = ex ^ (DW'(1) << $urandom_range(0, DW-1));
      write_slot(i, st, ky, ex);
    end
  endtask

  // One run: predict from the stored vectors, then watch the DUT cycle by cycle.
  task automatic run_check(input string name, input int nv, input bit lp, input int stop_at,
                           input bit disturb);
    int q[$];
    int n, passes, exp_err, exp_first, exp_busy, exp_vec, b, qi;
    n = (nv > DEP) ? DEP : nv;
    passes = (n == 0) ? 0 : (lp ? (stop_at + n - 1) / n : 1);
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < n; i++) q.push_back(i);
    exp_err = 0; exp_first = 0;
    foreach (q[k]) begin
      if (mex[q[k]] != (mst[q[k]] ^ mky[q[k]])) begin
        if (exp_err == 0) exp_first = q[k];
        exp_err++;
      end
    end
    exp_busy = (q.size() == 0) ? 0 : q.size() + LAT;

    @(negedge clk);
    num_vec = (AW+1)'(nv); loop_en = lp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    b = 0;
    while (busy && b < 4000) begin
      exp_vec = b - LAT;
      if (exp_vec < 0) exp_vec = 0;
      if (exp_vec > q.size()) exp_vec = q.size();
      qi = (b < q.size()) ? q[b] : -1;
      checks++;
      if (qi >= 0 && (core_state !== mst[qi] || core_key !== mky[qi])) begin
        errors++;
        $display("FAIL %s issue cycle %0d: state=%h key=%h, want slot %0d state=%h key=%h",
                 name, b, core_state, core_key, qi, mst[qi], mky[qi]);
      end else if (qi < 0 && (core_state !== '0 || core_key !== '0)) begin
        errors++;
        $display("FAIL %s drain cycle %0d: core_state=%h core_key=%h, want 0", name, b,
                 core_state, core_key);
      end
      checks++;
      if (vec_cnt !== 16'(exp_vec)) begin
        errors++;
        $display("FAIL %s vec_cnt at cycle %0d: got %0d want %0d", name, b, vec_cnt, exp_vec);
      end
      if (lp && stop_at > 0 && b == stop_at - 1) stop = 1'b1;
      if (disturb && b == 1) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = AW'(2);
        wr_state = rnd128(); wr_key = rnd128(); wr_exp = rnd128();
      end
      @(negedge clk);
      stop = 1'b0; start = 1'b0; wr_en = 1'b0;
      b++;
    end
    checks++;
    if (b >= 4000) begin
      errors++;
      $display("FAIL %s timeout: busy still high after %0d cycles", name, b);
    end
    checks++;
    if (b != exp_busy) begin
      errors++;
      $display("FAIL %s busy length: got %0d want %0d", name, b, exp_busy);
    end
    checks++;
    if (done !== 1'b1 || pass !== (exp_err == 0) || err_cnt !== 16'(exp_err) ||
        vec_cnt !== 16'(q.size()) || first_err_idx !== AW'(exp_first) ||
        core_state !== '0) begin
      errors++;
      $display("FAIL %s result: done=%b pass=%b err=%0d vec=%0d first=%0d cs=%h want done=1 pass=%b err=%0d vec=%0d first=%0d cs=0",
               name, done, pass, err_cnt, vec_cnt, first_err_idx, core_state,
               exp_err == 0, exp_err, q.size(), exp_first);
    end
    $display("run %s: nv=%0d loop=%0b stop_at=%0d busy=%0d vec=%0d err=%0d first=%0d pass=%b",
             name, nv, lp, stop_at, b, vec_cnt, err_cnt, first_err_idx, pass);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_cnt !== 16'd0 ||
        vec_cnt !== 16'd0 || first_err_idx !== '0 || core_state !== '0 || core_key !== '0) begin
      errors++;
      $display("FAIL reset outputs: busy=%b done=%b pass=%b err=%0d vec=%0d first=%0d, want all 0",
               busy, done, pass, err_cnt, vec_cnt, first_err_idx);
    end
    rst = 1'b1;
    $display("reset: outputs busy=%b done=%b vec=%0d", busy, done, vec_cnt);
  endtask

  task automatic test_known_vector();
    logic [DW-1:0] st, ky;
    st = 128'h3243f6a8885a308d313198a2e0370734;
    ky = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    write_slot(0, st, ky, st ^ ky);
    run_check("known_vector", 1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_single_error();
    fill_slots(8'b0010_0000);
    run_check("slot5_bad", 8, 1'b0, 0, 1'b0);
  endtask

  task automatic test_count_bounds();
    run_check("zero_count", 0, 1'b0, 0, 1'b0);
    run_check("clamp_12", 12, 1'b0, 0, 1'b0);
    run_check("clamp_15", 15, 1'b0, 0, 1'b0);
  endtask

  task automatic test_loop_stop();
    fill_slots(8'b0000_0100);
    run_check("loop_n3_stop5", 3, 1'b1, 5, 1'b0);
    run_check("loop_n4_stop4", 4, 1'b1, 4, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    int b;
    fill_slots(8'b1000_0001);
    @(negedge clk);
    num_vec = 4'd8; loop_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    b = 0;
    while (b < 2) begin @(negedge clk); b++; end
    checks++;
    if (core_state !== mst[2]) begin
      errors++;
      $display("FAIL midrst pre-reset slot2: got %h want %h", core_state, mst[2]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_cnt !== 16'd0 ||
        vec_cnt !== 16'd0 || first_err_idx !== '0 || core_state !== '0 || core_key !== '0) begin
      errors++;
      $display("FAIL midrst outputs: busy=%b done=%b err=%0d vec=%0d cs=%h, want all 0",
               busy, done, err_cnt, vec_cnt, core_state);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (LAT + 4) begin
      @(negedge clk);
      checks++;
      if (vec_cnt !== 16'd0 || err_cnt !== 16'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst stale: vec=%0d err=%0d busy=%b, want 0 0 0", vec_cnt, err_cnt, busy);
      end
    end
    $display("midrst: abandoned run, idle vec=%0d", vec_cnt);
    run_check("after_reset", 8, 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    fill_slots(8'b0000_0000);
    run_check("undisturbed", 8, 1'b0, 0, 1'b0);
    run_check("disturbed", 8, 1'b0, 0, 1'b1);
    run_check("again", 8, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int nv;
      bit lp;
      fill_slots(DEP'($urandom) & DEP'($urandom));
      nv = $urandom_range(1, 15);
      lp = 1'($urandom);
      run_check($sformatf("rand%0d", r), nv, lp, $urandom_range(1, 20), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_single_error();
    test_count_bounds();
    test_loop_stop();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
